// File: rtl/speed_pkg.sv
// Shared types and defaults for the speed controller's ADC sampling path.
package speed_pkg;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    WAIT_TICK,
    REQ,
    CONV,
    PUBLISH
  } seq_state_e;

  // Sample value meaning "stick centred / no acceleration".
  localparam logic [15:0] NEUTRAL_DATA = 16'h3200;

  // Default sample period and conversion timeout, in clock cycles.
  localparam int DEFAULT_SAMPLE_PERIOD = 10000;
  localparam int DEFAULT_TIMEOUT       = 1023;

endpackage

// File: rtl/period_tick_gen.sv
// Free-running sample-period counter; o_tick marks the last cycle of each period.
module period_tick_gen
  import speed_pkg::*;
#(
  parameter int PERIOD = DEFAULT_SAMPLE_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..PERIOD-1 and wrap; only reset ever disturbs the count.
  // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = (cnt == LAST);

endmodule

// File: rtl/adc_channel_sequencer.sv
// Round-robin conversion sequencer sharing one ADC between the speed controller channels.
// One request per sample tick; waits for the result with a timeout, then publishes it.
module adc_channel_sequencer
  import speed_pkg::*;
#(
  parameter int                NUM_CH        = 2,
  parameter int                CH_W          = 1,
  parameter int                DATA_W        = 16,
  parameter int                SAMPLE_PERIOD = DEFAULT_SAMPLE_PERIOD,
  parameter int                TIMEOUT       = DEFAULT_TIMEOUT,
  parameter logic [DATA_W-1:0] NEUTRAL_DATA  = DATA_W'(speed_pkg::NEUTRAL_DATA)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  output logic              o_adc_req,
  output logic [CH_W-1:0]   o_adc_ch,
  input  logic              i_adc_ack,
  input  logic              i_adc_valid,
  input  logic [DATA_W-1:0] i_adc_data,
  output logic [CH_W-1:0]   o_channel,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_timeout_err,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(TIMEOUT);
  localparam logic [CH_W-1:0] LAST_CH     = CH_W'(NUM_CH - 1);

  seq_state_e        state_q, state_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic              req_d;
  logic [CH_W-1:0]   adc_ch_d;
  logic [CH_W-1:0]   channel_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d, err_d, overrun_d, busy_d;
  logic              tick;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    return (ch == LAST_CH) ? '0 : ch + CH_W'(1);
  endfunction

  period_tick_gen #(
    .PERIOD (SAMPLE_PERIOD)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

  // Next-state and next-output decode for the sequencer.
  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cur_ch_d  = cur_ch_q;
    tcnt_d    = tcnt_q;
    cap_d     = cap_q;
    req_d     = o_adc_req;
    adc_ch_d  = o_adc_ch;
    channel_d = o_channel;
    data_d    = o_data;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    overrun_d = tick && (state_q != WAIT_TICK);

    case (state_q)
      WAIT_TICK: begin
        if (tick && i_enable) begin
          state_d  = REQ;
          req_d    = 1'b1;
          adc_ch_d = cur_ch_q;
        end
      end
      REQ: begin
        if (i_adc_ack) begin
          state_d = CONV;
          req_d   = 1'b0;
          tcnt_d  = '0;
        end
      end
      CONV: begin
        if (i_adc_valid) begin
          cap_d   = i_adc_data;
          state_d = PUBLISH;
        end else if (tcnt_q == TIMEOUT_CNT) begin
          err_d    = 1'b1;
          cur_ch_d = next_ch(cur_ch_q);
          state_d  = WAIT_TICK;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      PUBLISH: begin
        data_d    = cap_q;
        channel_d = cur_ch_q;
        valid_d   = 1'b1;
        cur_ch_d  = next_ch(cur_ch_q);
        state_d   = WAIT_TICK;
      end
      default: state_d = WAIT_TICK;
    endcase

    busy_d = (state_d == REQ) || (state_d == CONV);
  end

  // State, counters and all outputs registered; reset abandons any conversion in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= WAIT_TICK;
      cur_ch_q      <= '0;
      tcnt_q        <= '0;
      cap_q         <= '0;
      o_adc_req     <= 1'b0;
      o_adc_ch      <= '0;
      o_channel     <= '0;
      o_data        <= NEUTRAL_DATA;
      o_valid       <= 1'b0;
      o_timeout_err <= 1'b0;
      o_overrun     <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_ch_q      <= cur_ch_d;
      tcnt_q        <= tcnt_d;
      cap_q         <= cap_d;
      o_adc_req     <= req_d;
      o_adc_ch      <= adc_ch_d;
      o_channel     <= channel_d;
      o_data        <= data_d;
      o_valid       <= valid_d;
      o_timeout_err <= err_d;
      o_overrun     <= overrun_d;
      o_busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Scoreboard bench: an ADC responder issues randomized transactions and pushes the
// expected publish/timeout/overrun events; a monitor pops and compares them.
module tb_adc_channel_sequencer;

  localparam int P    = 1200;
  localparam int TO   = 1023;
  localparam int NCH  = 2;
  localparam int CHW  = 1;
  localparam int DW   = 16;
  localparam logic [DW-1:0] NEUTRAL = 16'h3200;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          ack;
  logic          valid;
  logic [DW-1:0] adc_data;
  logic          o_adc_req;
  logic [CHW-1:0] o_adc_ch;
  logic [CHW-1:0] o_channel;
  logic [DW-1:0] o_data;
  logic          o_valid, o_timeout_err, o_overrun, o_busy;

  always #5 clk = ~clk;

  adc_channel_sequencer #(
    .NUM_CH        (NCH),
    .CH_W          (CHW),
    .DATA_W        (DW),
    .SAMPLE_PERIOD (P),
    .TIMEOUT       (TO),
    .NEUTRAL_DATA  (NEUTRAL)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (en),
    .o_adc_req     (o_adc_req),
    .o_adc_ch      (o_adc_ch),
    .i_adc_ack     (ack),
    .i_adc_valid   (valid),
    .i_adc_data    (adc_data),
    .o_channel     (o_channel),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_timeout_err (o_timeout_err),
    .o_overrun     (o_overrun),
    .o_busy        (o_busy)
  );

  typedef struct {
    bit          is_to;
    int          cyc;
    int          ch;
    logic [15:0] data;
  } exp_t;

  exp_t pub_q[$];
  int   ovr_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc;

  // Reference model state (transaction level).
  int          m_ch;
  int          m_pub_ch;
  logic [15:0] m_pub_data;
  int          last_end;
  int          en_since;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles since reset release; the DUT period counter starts at the same point.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Monitor: compare every publish/timeout/overrun pulse against the scoreboard.
  exp_t mon_e;
  int   mon_o;
  always @(negedge clk) begin
    if (!rst) begin
      if (pub_q.size() > 0 && pub_q[0].cyc < cyc) begin
        mon_e = pub_q.pop_front();
        check("missing_event_cycle", cyc, mon_e.cyc);
      end
      if (o_valid || o_timeout_err) begin
        if (pub_q.size() == 0) begin
          check("unexpected_valid_or_timeout", {o_valid, o_timeout_err}, 0);
        end else begin
          mon_e = pub_q.pop_front();
          check("event_cycle", cyc, mon_e.cyc);
          check("event_timeout_flag", o_timeout_err, mon_e.is_to);
          check("event_valid_flag", o_valid, !mon_e.is_to);
          check("event_channel", 32'(o_channel), mon_e.ch);
          check("event_data", 32'(o_data), 32'(mon_e.data));
        end
      end
      if (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
        mon_o = ovr_q.pop_front();
        check("missing_overrun_cycle", cyc, mon_o);
      end
      if (o_overrun) begin
        if (ovr_q.size() == 0) check("unexpected_overrun", 1, 0);
        else begin
          mon_o = ovr_q.pop_front();
          check("overrun_cycle", cyc, mon_o);
        end
      end
    end
  end

  // Cycle at which the next request must appear: the tick following both the end of the
  // previous transaction and the point enable became visible, plus one registered cycle.
  function automatic int exp_req_cycle();
    int n0 = (last_end + 1 > en_since) ? last_end + 1 : en_since;
    int n  = n0 + ((P - 1 - (n0 % P)) + P) % P;
    return n + 1;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_adc_req"}, o_adc_req, 0);
    check({tag, "_adc_ch"}, 32'(o_adc_ch), 0);
    check({tag, "_channel"}, 32'(o_channel), 0);
    check({tag, "_data"}, 32'(o_data), 32'(NEUTRAL));
    check({tag, "_pulses"}, {o_valid, o_timeout_err, o_overrun}, 0);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  task automatic reset_model();
    m_ch       = 0;
    m_pub_ch   = 0;
    m_pub_data = NEUTRAL;
    last_end   = -1;
    en_since   = 0;
  endtask

  // One ADC transaction. Caller is positioned on a negedge in WAIT_TICK/REQ.
  task automatic run_txn(input int ack_dly, input bit do_to, input int conv_dly,
                         input logic [15:0] data, input bit drop_en, input bit spur);
    int   r, c, last, waited, req_ch;
    exp_t e;
    if (spur) begin
      valid = 1'b1; adc_data = 16'($urandom);
      @(negedge clk);
      valid = 1'b0;
    end
    waited = 0;
    while (!o_adc_req && waited < 3 * P) begin
      @(negedge clk);
      waited++;
    end
    if (!o_adc_req) begin
      check("request_wait_expired", 0, 1);
      return;
    end
    r = cyc;
    req_ch = m_ch;
    check("request_cycle", r, exp_req_cycle());
    check("request_channel", 32'(o_adc_ch), req_ch);
    check("busy_during_request", o_busy, 1);

    c    = r + ack_dly;
    last = do_to ? c + TO + 1 : c + conv_dly + 1;
    for (int n = r; n <= last; n++) if (n % P == P - 1) ovr_q.push_back(n + 1);
    if (do_to) begin
      e = '{is_to: 1'b1, cyc: c + TO + 2, ch: m_pub_ch, data: m_pub_data};
    end else begin
      e = '{is_to: 1'b0, cyc: c + conv_dly + 2, ch: req_ch, data: data};
      m_pub_ch   = req_ch;
      m_pub_data = data;
    end
    pub_q.push_back(e);
    m_ch = (m_ch + 1) % NCH;
    if (drop_en) en = 1'b0;

    while (cyc < c) @(negedge clk);
    check("request_held_until_ack", {o_adc_req, 31'(o_adc_ch)}, {1'b1, 31'(req_ch)});
    ack = 1'b1;
    if (spur) begin
      valid = 1'b1; adc_data = 16'($urandom);
    end
    @(negedge clk);
    ack = 1'b0; valid = 1'b0;
    if (!do_to) begin
      while (cyc < c + conv_dly) @(negedge clk);
      valid = 1'b1; adc_data = data;
      @(negedge clk);
      valid = 1'b0;
    end
    while (cyc < last + 1) @(negedge clk);
    last_end = last;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs, waited, sel, ad, cd;
    bit tflag;
    rst = 1'b1; en = 1'b0; ack = 1'b0; valid = 1'b0; adc_data = '0;
    reset_model();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Idle with enable low: no requests, outputs hold neutral values.
    reqs = 0;
    repeat (4 * P) begin
      @(negedge clk);
      if (o_adc_req) reqs++;
    end
    check("idle_request_count", reqs, 0);
    check("idle_data", 32'(o_data), 32'(NEUTRAL));
    check("idle_channel", 32'(o_channel), 0);

    en = 1'b1; en_since = cyc;
    run_txn(2, 0, 5, 16'h4A00, 0, 0);            // ch0 publishes 4A00
    run_txn(2, 0, 5, 16'($urandom), 0, 0);      // ch1
    run_txn(2, 1, 0, 16'h0000, 0, 0);           // ch0 times out, data held
    run_txn(P + P / 5, 0, 3, 16'($urandom), 0, 0); // ch1, long ack hold spans a tick
    run_txn(1, 0, TO + 1, 16'($urandom), 0, 0); // valid on the timeout cycle wins
    run_txn(3, 0, 4, 16'($urandom), 0, 1);      // stray valids outside CONV
    run_txn(2, 0, 6, 16'($urandom), 1, 0);      // enable drops mid-transaction

    reqs = 0;
    repeat (2 * P) begin
      @(negedge clk);
      if (o_adc_req) reqs++;
    end
    check("disabled_request_count", reqs, 0);
    en = 1'b1; en_since = cyc;

    for (int i = 0; i < 10; i++) begin
      sel = int'($urandom_range(0, 99));
      ad  = (sel < 70) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, P));
      sel = int'($urandom_range(0, 99));
      tflag = (sel < 15);
      sel = int'($urandom_range(0, 99));
      cd  = (sel < 70) ? int'($urandom_range(1, 8)) :
            (sel < 90) ? int'($urandom_range(1, TO + 1)) : TO + 1;
      run_txn(ad, tflag, cd, 16'($urandom), 0, $urandom_range(0, 3) == 0);
    end

    // Reset in the middle of a conversion; a late result must be ignored.
    waited = 0;
    while (!o_adc_req && waited < 3 * P) begin
      @(negedge clk);
      waited++;
    end
    check("pre_reset_request_seen", o_adc_req, 1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_in_conversion", o_busy, 1);
    rst = 1'b1;
    pub_q.delete();
    ovr_q.delete();
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    valid = 1'b1; adc_data = 16'hBEEF;
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_vals("after_midconv_reset");
    run_txn(2, 0, 5, 16'($urandom), 0, 0);      // sequence restarts on ch0

    repeat (5) @(negedge clk);
    check("scoreboard_drained", pub_q.size(), 0);
    check("overrun_queue_drained", ovr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
